instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_isa_pkg.sv | 35 +++
 rtl/instr_word_pack.sv | 34 +++
 rtl/instr_encoder.sv | 95 +++++++++
 tb/tb_instr_encoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_isa_pkg.sv
// Shared MIPS-subset ISA definitions: operation codes, primary opcodes and R-type funct values.
// Used by both the instruction encoder and the decode side.
package mips_isa_pkg;

    typedef enum logic [3:0] {
        OP_AND   = 4'd0,
        OP_OR    = 4'd1,
        OP_ADD   = 4'd2,
        OP_ADDU  = 4'd3,
        OP_MULT  = 4'd4,
        OP_J     = 4'd5,
        OP_ANDI  = 4'd6,
        OP_ORI   = 4'd7,
        OP_ADDI  = 4'd8,
        OP_ADDIU = 4'd9
    } op_e;

    localparam logic [5:0] OPC_RTYPE = 6'd0;
    localparam logic [5:0] OPC_J     = 6'd2;
    localparam logic [5:0] OPC_ADDI  = 6'd8;
    localparam logic [5:0] OPC_ADDIU = 6'd9;
    localparam logic [5:0] OPC_ANDI  = 6'd12;
    localparam logic [5:0] OPC_ORI   = 6'd13;

    localparam logic [5:0] FN_MULT = 6'd24;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_ADDU = 6'd33;
    localparam logic [5:0] FN_AND  = 6'd36;
    localparam logic [5:0] FN_OR   = 6'd37;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_ADDIU;
    endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packing of one operation and its operand fields into a 32-bit instruction word.
// Fields not used by the selected format are ignored; codes above ADDIU raise illegal.
module instr_word_pack
    import mips_isa_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'd0;
        illegal = !op_is_legal(op);
        case (op)
            OP_AND:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            OP_OR:    word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            OP_ADD:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            OP_ADDU:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
            OP_MULT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_MULT};
            OP_J:     word = {OPC_J, target};
            OP_ANDI:  word = {OPC_ANDI, rs, rt, imm};
            OP_ORI:   word = {OPC_ORI, rs, rt, imm};
            OP_ADDI:  word = {OPC_ADDI, rs, rt, imm};
            OP_ADDIU: word = {OPC_ADDIU, rs, rt, imm};
            default:  word = 32'd0;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Sequencer that accepts encode requests and streams packed words into instruction memory.
// Optional INSTR_ENCODER_CHECKSUM_EN adds a running XOR of every strobed word.
module instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        op,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
`ifdef INSTR_ENCODER_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

    logic [31:0]       word;
    logic              illegal;
    logic [ADDR_W-1:0] wr_ptr;
    logic              we_q;
    logic              accept;

    instr_word_pack u_pack (
        .op      (op),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .imm     (imm),
        .target  (target),
        .word    (word),
        .illegal (illegal)
    );

    assign full      = (count == FULL_CNT);
    assign req_ready = !full && !clear && !rst;
    assign accept    = req_valid && req_ready;
    // A strobe registered on the edge before rst rises is suppressed here.
    assign imem_we   = we_q && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q       <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            wr_ptr     <= '0;
            count      <= '0;
            err        <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (clear) begin
                wr_ptr <= '0;
                count  <= '0;
                err    <= 1'b0;
            end else if (accept) begin
                if (illegal) begin
                    err <= 1'b1;
                end else begin
                    we_q       <= 1'b1;
                    imem_addr  <= wr_ptr;
                    imem_wdata <= word;
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    count      <= count + (ADDR_W + 1)'(1);
                end
            end
        end
    end

`ifdef INSTR_ENCODER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            checksum <= 32'd0;
        end else if (accept && !illegal) begin
            checksum <= checksum ^ word;
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: per-cycle comparison against a behavioural model
// plus directed vectors with hand-computed words.
module tb_instr_encoder;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    localparam int FN_TAB  [5] = '{36, 37, 32, 33, 24};
    localparam int OPC_TAB [4] = '{12, 13, 8, 9};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        op = 4'd0;
    logic [4:0]        rs = 5'd0, rt = 5'd0, rd = 5'd0;
    logic [15:0]       imm = 16'd0;
    logic [25:0]       target = 26'd0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;
`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int total  = 0;
    int passed = 0;
    bit started = 1'b0;

    instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .target     (target),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
`ifdef INSTR_ENCODER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        else
            passed++;
    endtask

    // Instruction word from field values by positional arithmetic.
    function automatic logic [31:0] model_word(input int o, input int s, input int t,
                                               input int d, input int i, input int g);
        longint w;
        if (o <= 4)       w = longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + longint'(d) * (1 << 11) + FN_TAB[o];
        else if (o == 5)  w = 2 * longint'(1 << 26) + g;
        else              w = longint'(OPC_TAB[o - 6]) * (1 << 26) + longint'(s) * (1 << 21) + longint'(t) * (1 << 16) + i;
        return w[31:0];
    endfunction

    bit          m_we;
    int          m_addr, m_ptr, m_count;
    logic [31:0] m_wdata, m_cks;
    bit          m_err;

    always @(posedge clk) begin
        if (rst) begin
            m_we <= 0; m_addr <= 0; m_wdata <= 0; m_ptr <= 0; m_count <= 0; m_err <= 0; m_cks <= 0;
        end else begin
            m_we <= 0;
            if (clear) begin
                m_ptr <= 0; m_count <= 0; m_err <= 0; m_cks <= 0;
            end else if (req_valid && m_count < DEPTH) begin
                if (op > 9) begin
                    m_err <= 1;
                end else begin
                    m_we    <= 1;
                    m_addr  <= m_ptr;
                    m_wdata <= model_word(op, rs, rt, rd, imm, target);
                    m_cks   <= m_cks ^ model_word(op, rs, rt, rd, imm, target);
                    m_ptr   <= (m_ptr + 1) % DEPTH;
                    m_count <= m_count + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("req_ready",  32'(req_ready),  32'(!rst && !clear && m_count < DEPTH));
            check("imem_we",    32'(imem_we),    32'(m_we && !rst));
            check("imem_addr",  32'(imem_addr),  32'(m_addr));
            check("imem_wdata", imem_wdata,      m_wdata);
            check("count",      32'(count),      32'(m_count));
            check("full",       32'(full),       32'(m_count == DEPTH));
            check("err",        32'(err),        32'(m_err));
`ifdef INSTR_ENCODER_CHECKSUM_EN
            check("checksum",   checksum,        m_cks);
`endif
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int o, input int s, input int t, input int d, input int i, input int g);
        req_valid = 1'b1;
        op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i); target = 26'(g);
    endtask

    task automatic do_clear();
        req_valid = 1'b0;
        clear = 1'b1;
        cycle();
        clear = 1'b0;
    endtask

    initial begin
        cycle();
        cycle();
        started = 1'b1;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_we",    32'(imem_we),   32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata,     32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_full",  32'(full),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        cycle();
        rst = 1'b0;

        // ADD rs=1 rt=2 rd=3, imm/target set to junk that must be ignored
        drive(2, 1, 2, 3, 16'hBEEF, 26'h3FFFFFF);
        cycle();
        req_valid = 1'b0;
        #1;
        check("add_we",    32'(imem_we),   32'd1);
        check("add_addr",  32'(imem_addr), 32'd0);
        check("add_wdata", imem_wdata,     32'h00221820);
        check("add_count", 32'(count),     32'd1);
        check("model_add", model_word(2, 1, 2, 3, 0, 0), 32'h00221820);
        do_clear();

        // ADDI then J back-to-back
        drive(8, 4, 5, 31, 16'hFFFF, 0);
        cycle();
        drive(5, 7, 9, 11, 16'h1234, 26'h0000010);
        #1;
        check("addi_we",    32'(imem_we),   32'd1);
        check("addi_addr",  32'(imem_addr), 32'd0);
        check("addi_wdata", imem_wdata,     32'h2085FFFF);
        cycle();
        req_valid = 1'b0;
        #1;
        check("j_we",    32'(imem_we),   32'd1);
        check("j_addr",  32'(imem_addr), 32'd1);
        check("j_wdata", imem_wdata,     32'h08000010);
        check("model_j", model_word(5, 0, 0, 0, 0, 26'h10), 32'h08000010);
        do_clear();

        // ADD, illegal op 12, ORI
        drive(2, 1, 2, 3, 0, 0);
        cycle();
        drive(12, 1, 1, 1, 1, 1);
        cycle();
        drive(7, 0, 1, 31, 5, 26'h155);
        #1;
        check("ill_we",    32'(imem_we), 32'd0);
        check("ill_err",   32'(err),     32'd1);
        check("ill_count", 32'(count),   32'd1);
        cycle();
        req_valid = 1'b0;
        #1;
        check("ori_we",    32'(imem_we),   32'd1);
        check("ori_addr",  32'(imem_addr), 32'd1);
        check("ori_wdata", imem_wdata,     32'h34010005);
        check("ori_err",   32'(err),       32'd1);
        check("model_ori", model_word(7, 0, 1, 0, 5, 0), 32'h34010005);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        check("cks_xor", checksum, 32'h34231825);
`endif

        // rst the cycle after an accept drops the strobe
        drive(0, 3, 3, 3, 0, 0);
        cycle();
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid_we", 32'(imem_we), 32'd0);
        cycle();
        rst = 1'b0;
        #1;
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_err",   32'(err),   32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        check("rstmid_cks", checksum, 32'd0);
`endif

        // five requests held valid into DEPTH=4
        for (int i = 0; i < 5; i++) begin
            drive(4, i, i + 1, i + 2, 0, 0);
            cycle();
        end
        #1;
        check("full_full",  32'(full),      32'd1);
        check("full_ready", 32'(req_ready), 32'd0);
        check("full_count", 32'(count),     32'd4);
        check("full_we",    32'(imem_we),   32'd0);
        check("full_addr",  32'(imem_addr), 32'd3);
        req_valid = 1'b0;
        do_clear();

        // clear alongside a new request the cycle after an accept
        drive(0, 1, 2, 7, 0, 0);
        cycle();
        clear = 1'b1;
        drive(7, 0, 1, 0, 5, 0);
        #1;
        check("clr_ready", 32'(req_ready), 32'd0);
        check("clr_we",    32'(imem_we),   32'd1);
        check("clr_addr",  32'(imem_addr), 32'd0);
        cycle();
        clear = 1'b0;
        req_valid = 1'b0;
        #1;
        check("clr_after_we",    32'(imem_we), 32'd0);
        check("clr_after_count", 32'(count),   32'd0);
        drive(7, 0, 1, 0, 5, 0);
        cycle();
        req_valid = 1'b0;
        #1;
        check("clr_next_addr",  32'(imem_addr), 32'd0);
        check("clr_next_wdata", imem_wdata,     32'h34010005);
        cycle();
        cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
